// File: rtl/clock_pkg.sv
// Shared timekeeping types and limits, reused by the display-side blocks.
// Holds no logic, so it adds no latency and applies no backpressure.
package clock_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t SEC_MAX = 8'h59;
    localparam bcd2_t MIN_MAX = 8'h59;
    localparam bcd2_t HR_MAX  = 8'h23;

    localparam int TICK_DIV_DEFAULT = 50_000_000;

    // True when both nibbles hold a legal decimal digit.
    function automatic logic bcd2_ok(input bcd2_t v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/clock_time_bcd_counter_if.sv
// Control inputs and BCD time outputs of the timekeeping core.
// Plain wires; the core registers every output and has no backpressure.
interface clock_time_bcd_counter_if;
    import clock_pkg::*;

    logic  i_En;
    logic  i_Set;
    logic  i_IncMin;
    logic  i_IncHr;
    bcd2_t o_Sec;
    bcd2_t o_Min;
    bcd2_t o_Hr;
    logic  o_SecPulse;
    logic  o_DayWrap;

    modport master (
        output i_En, i_Set, i_IncMin, i_IncHr,
        input  o_Sec, o_Min, o_Hr, o_SecPulse, o_DayWrap
    );

    modport slave (
        input  i_En, i_Set, i_IncMin, i_IncHr,
        output o_Sec, o_Min, o_Hr, o_SecPulse, o_DayWrap
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX; clr wins over inc.
// Value updates one cycle after inc/clr; carry is combinational, wrap registered; no backpressure.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd2_t MAX = SEC_MAX
) (
    input  logic  i_Clk,
    input  logic  i_pRst,
    input  logic  inc,
    input  logic  clr,
    input  logic  wrap_en,
    output bcd2_t value,
    output logic  carry,
    output logic  wrap
);

    logic  at_max;
    bcd2_t next_val;

    assign at_max = (value == MAX);
    // Same-edge carry so a full rollover lands on one edge across all stages.
    assign carry  = inc & at_max;

    always_comb begin
        next_val = value;
        if (clr) begin
            next_val = '0;
        end else if (inc) begin
            if (at_max) begin
                next_val = '0;
            end else if (value[3:0] == 4'd9) begin
                next_val = {value[7:4] + 4'd1, 4'd0};
            end else begin
                next_val = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_pRst) begin
        if (i_pRst) begin
            value <= '0;
            wrap  <= 1'b0;
        end else begin
            value <= next_val;
            wrap  <= carry & wrap_en;
        end
    end

endmodule

// File: rtl/clock_time_bcd_counter.sv
// 24-hour BCD timekeeper: prescaler to a one-second tick, then sec/min/hr counters with set mode.
// Outputs change one cycle after the tick or increment edge; no backpressure, i_En only stalls.
module clock_time_bcd_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int PW       = 26
) (
    input  logic                     i_Clk,
    input  logic                     i_pRst,
    clock_time_bcd_counter_if.slave  ctl
);

    logic [PW-1:0] presc;
    logic          run;
    logic          tick;
    logic          sec_pulse;

    bcd2_t sec_val;
    bcd2_t min_val;
    bcd2_t hr_val;
    logic  sec_carry;
    logic  min_carry;
    logic  hr_carry;
    logic  sec_wrap;
    logic  min_wrap;
    logic  hr_wrap;
    logic  min_inc;
    logic  hr_inc;
    logic  unused_wraps;

    // Set mode overrides the run enable and freezes the prescaler at zero.
    assign run  = ctl.i_En & ~ctl.i_Set;
    assign tick = run && (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge i_Clk or posedge i_pRst) begin
        if (i_pRst) begin
            presc <= '0;
        end else if (ctl.i_Set) begin
            presc <= '0;
        end else if (run) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge i_Clk or posedge i_pRst) begin
        if (i_pRst) begin
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= tick;
        end
    end

    // In set mode the manual pulses replace the natural carry chain, so
    // minutes never carry into hours there.
    assign min_inc = ctl.i_Set ? ctl.i_IncMin : sec_carry;
    assign hr_inc  = ctl.i_Set ? ctl.i_IncHr  : min_carry;

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .i_Clk   (i_Clk),
        .i_pRst  (i_pRst),
        .inc     (tick),
        .clr     (ctl.i_Set),
        .wrap_en (1'b1),
        .value   (sec_val),
        .carry   (sec_carry),
        .wrap    (sec_wrap)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .i_Clk   (i_Clk),
        .i_pRst  (i_pRst),
        .inc     (min_inc),
        .clr     (1'b0),
        .wrap_en (1'b1),
        .value   (min_val),
        .carry   (min_carry),
        .wrap    (min_wrap)
    );

    // Hour wrap only counts as a day rollover when it came from natural ticking.
    bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
        .i_Clk   (i_Clk),
        .i_pRst  (i_pRst),
        .inc     (hr_inc),
        .clr     (1'b0),
        .wrap_en (~ctl.i_Set),
        .value   (hr_val),
        .carry   (hr_carry),
        .wrap    (hr_wrap)
    );

    assign unused_wraps = sec_wrap ^ min_wrap ^ hr_carry;

    assign ctl.o_Sec      = sec_val;
    assign ctl.o_Min      = min_val;
    assign ctl.o_Hr       = hr_val;
    assign ctl.o_SecPulse = sec_pulse;
    assign ctl.o_DayWrap  = hr_wrap;

endmodule

// File: tb/tb_clock_time_bcd_counter.sv
// Directed bench for the BCD timekeeper at TICK_DIV = 4.
// Drives and samples on the falling edge, away from the active rising edge.
module tb_clock_time_bcd_counter;
    import clock_pkg::*;

    logic i_Clk;
    logic i_pRst;
    int   checks;
    int   errors;
    int   bcd_bad;

    clock_time_bcd_counter_if bus ();

    clock_time_bcd_counter #(.TICK_DIV(4), .PW(3)) dut (
        .i_Clk  (i_Clk),
        .i_pRst (i_pRst),
        .ctl    (bus.slave)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Every digit legal and every field within its range, on every cycle.
    always @(negedge i_Clk) begin
        if (!i_pRst) begin
            if (!bcd2_ok(bus.o_Sec) || !bcd2_ok(bus.o_Min) || !bcd2_ok(bus.o_Hr) ||
                bus.o_Sec > SEC_MAX || bus.o_Min > MIN_MAX || bus.o_Hr > HR_MAX)
                bcd_bad++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From the cycle after a tick (or reset release / set exit): three quiet
    // cycles, then a one-cycle pulse carrying the new seconds value.
    task automatic expect_tick(input string tag, input logic [7:0] exp_sec);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk({tag, "_quiet"}, {31'd0, bus.o_SecPulse}, 32'd0);
        end
        step(1);
        chk({tag, "_pulse"}, {31'd0, bus.o_SecPulse}, 32'd1);
        chk({tag, "_sec"}, {24'd0, bus.o_Sec}, {24'd0, exp_sec});
    endtask

    task automatic hold_inc(input logic min_p, input logic hr_p, input int n);
        bus.i_IncMin = min_p;
        bus.i_IncHr  = hr_p;
        step(n);
        bus.i_IncMin = 1'b0;
        bus.i_IncHr  = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        bcd_bad      = 0;
        i_pRst       = 1'b1;
        bus.i_En     = 1'b1;
        bus.i_Set    = 1'b0;
        bus.i_IncMin = 1'b0;
        bus.i_IncHr  = 1'b0;

        step(2);
        chk("rst_sec", {24'd0, bus.o_Sec}, 32'h00);
        chk("rst_min", {24'd0, bus.o_Min}, 32'h00);
        chk("rst_hr", {24'd0, bus.o_Hr}, 32'h00);
        chk("rst_pulse", {31'd0, bus.o_SecPulse}, 32'd0);
        chk("rst_daywrap", {31'd0, bus.o_DayWrap}, 32'd0);

        i_pRst = 1'b0;
        expect_tick("first", 8'h01);
        expect_tick("second", 8'h02);
        expect_tick("third", 8'h03);

        step(4 * 6);
        chk("sec_09", {24'd0, bus.o_Sec}, 32'h09);
        step(4);
        chk("sec_10", {24'd0, bus.o_Sec}, 32'h10);
        step(4 * 49);
        chk("sec_59", {24'd0, bus.o_Sec}, 32'h59);
        chk("sec_59_min", {24'd0, bus.o_Min}, 32'h00);
        step(4);
        chk("min_carry_sec", {24'd0, bus.o_Sec}, 32'h00);
        chk("min_carry_min", {24'd0, bus.o_Min}, 32'h01);
        chk("min_carry_pulse", {31'd0, bus.o_SecPulse}, 32'd1);

        // Stall 10 cycles with the prescaler at 2: the tick lands 10 cycles late.
        step(2);
        bus.i_En = 1'b0;
        step(10);
        chk("stall_pulse", {31'd0, bus.o_SecPulse}, 32'd0);
        chk("stall_sec", {24'd0, bus.o_Sec}, 32'h00);
        bus.i_En = 1'b1;
        step(1);
        chk("stall_resume_quiet", {31'd0, bus.o_SecPulse}, 32'd0);
        step(1);
        chk("stall_resume_pulse", {31'd0, bus.o_SecPulse}, 32'd1);
        chk("stall_resume_sec", {24'd0, bus.o_Sec}, 32'h01);

        hold_inc(1'b1, 1'b1, 1);
        chk("ign_inc_hr", {24'd0, bus.o_Hr}, 32'h00);
        chk("ign_inc_min", {24'd0, bus.o_Min}, 32'h01);

        step(3);
        chk("after_ign_sec", {24'd0, bus.o_Sec}, 32'h02);
        step(4 * 35);
        chk("sec_37", {24'd0, bus.o_Sec}, 32'h37);
        step(2);

        bus.i_Set = 1'b1;
        step(1);
        chk("set_sec_clr", {24'd0, bus.o_Sec}, 32'h00);
        chk("set_no_pulse", {31'd0, bus.o_SecPulse}, 32'd0);
        step(3);
        chk("set_hold_pulse", {31'd0, bus.o_SecPulse}, 32'd0);
        chk("set_hold_sec", {24'd0, bus.o_Sec}, 32'h00);

        hold_inc(1'b1, 1'b0, 58);
        chk("set_min_59", {24'd0, bus.o_Min}, 32'h59);
        hold_inc(1'b1, 1'b0, 1);
        chk("set_min_wrap", {24'd0, bus.o_Min}, 32'h00);
        chk("set_min_wrap_hr", {24'd0, bus.o_Hr}, 32'h00);

        hold_inc(1'b0, 1'b1, 9);
        chk("hr_09", {24'd0, bus.o_Hr}, 32'h09);
        hold_inc(1'b0, 1'b1, 1);
        chk("hr_10", {24'd0, bus.o_Hr}, 32'h10);
        hold_inc(1'b0, 1'b1, 9);
        chk("hr_19", {24'd0, bus.o_Hr}, 32'h19);
        hold_inc(1'b0, 1'b1, 1);
        chk("hr_20", {24'd0, bus.o_Hr}, 32'h20);
        hold_inc(1'b0, 1'b1, 3);
        chk("hr_23", {24'd0, bus.o_Hr}, 32'h23);
        hold_inc(1'b1, 1'b0, 59);
        chk("min_59_at_23", {24'd0, bus.o_Min}, 32'h59);

        hold_inc(1'b1, 1'b1, 1);
        chk("both_min", {24'd0, bus.o_Min}, 32'h00);
        chk("both_hr", {24'd0, bus.o_Hr}, 32'h00);
        chk("both_daywrap", {31'd0, bus.o_DayWrap}, 32'd0);

        hold_inc(1'b0, 1'b1, 23);
        hold_inc(1'b1, 1'b0, 59);
        bus.i_Set = 1'b0;
        expect_tick("set_exit", 8'h01);
        step(4 * 58);
        chk("pre_wrap_sec", {24'd0, bus.o_Sec}, 32'h59);
        chk("pre_wrap_min", {24'd0, bus.o_Min}, 32'h59);
        chk("pre_wrap_hr", {24'd0, bus.o_Hr}, 32'h23);
        chk("pre_wrap_daywrap", {31'd0, bus.o_DayWrap}, 32'd0);
        step(4);
        chk("wrap_sec", {24'd0, bus.o_Sec}, 32'h00);
        chk("wrap_min", {24'd0, bus.o_Min}, 32'h00);
        chk("wrap_hr", {24'd0, bus.o_Hr}, 32'h00);
        chk("wrap_pulse", {31'd0, bus.o_SecPulse}, 32'd1);
        chk("wrap_daywrap", {31'd0, bus.o_DayWrap}, 32'd1);
        step(1);
        chk("wrap_daywrap_end", {31'd0, bus.o_DayWrap}, 32'd0);
        chk("wrap_pulse_end", {31'd0, bus.o_SecPulse}, 32'd0);

        // Build 12:34:56, then reset between clock edges.
        bus.i_Set = 1'b1;
        hold_inc(1'b0, 1'b1, 12);
        hold_inc(1'b1, 1'b0, 34);
        bus.i_Set = 1'b0;
        step(4 * 56);
        chk("pre_rst_sec", {24'd0, bus.o_Sec}, 32'h56);
        chk("pre_rst_min", {24'd0, bus.o_Min}, 32'h34);
        chk("pre_rst_hr", {24'd0, bus.o_Hr}, 32'h12);
        chk("pre_rst_pulse", {31'd0, bus.o_SecPulse}, 32'd1);
        #2;
        i_pRst = 1'b1;
        #1;
        chk("async_rst_sec", {24'd0, bus.o_Sec}, 32'h00);
        chk("async_rst_min", {24'd0, bus.o_Min}, 32'h00);
        chk("async_rst_hr", {24'd0, bus.o_Hr}, 32'h00);
        chk("async_rst_pulse", {31'd0, bus.o_SecPulse}, 32'd0);
        @(negedge i_Clk);
        i_pRst = 1'b0;
        expect_tick("post_rst", 8'h01);

        chk("bcd_monitor", bcd_bad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_time_bcd_counter.md
# clock_time_bcd_counter

Timekeeping core of the digital clock. It divides the system clock down to a one-second tick and keeps hours, minutes and seconds as packed two-digit BCD in 24-hour format. It supports a manual set mode for minutes and hours. It sits upstream of the display pipeline: its BCD outputs and second pulse are registered by the downstream n-bit reset-to-one register stage, which in turn feeds digit selection and 7-segment decode.

## Interface
- `TICK_DIV`, default 50_000_000: system clocks per second. Must be ≥ 2.
- `PW`, default 26: prescaler width. Must satisfy `2^PW ≥ TICK_DIV`.
- `i_Clk`, in, 1: system clock. All state changes on its rising edge.
- `i_pRst`, in, 1: reset, asynchronous and active-high. Clears all state immediately.
- `i_En`, in, 1: run enable. When low, the prescaler and time freeze.
- `i_Set`, in, 1: set mode. Level-sensitive.
- `i_IncMin`, in, 1: one-cycle pulse. Increments minutes. Honoured only when `i_Set` is high.
- `i_IncHr`, in, 1: one-cycle pulse. Increments hours. Honoured only when `i_Set` is high.
- `o_Sec`, out, 8: seconds, BCD, {tens[7:4], units[3:0]}, range 00–59.
- `o_Min`, out, 8: minutes, BCD, range 00–59.
- `o_Hr`, out, 8: hours, BCD, range 00–23.
- `o_SecPulse`, out, 1: one-cycle pulse when seconds advance by natural ticking.
- `o_DayWrap`, out, 1: one-cycle pulse when 23:59:59 rolls over to 00:00:00.

## Operation
- **Reset** (`i_pRst` high): prescaler = 0, `o_Sec` = `o_Min` = `o_Hr` = 8'h00, `o_SecPulse` = `o_DayWrap` = 0. Effect is immediate and asynchronous. Reset asserted mid-count discards any partial second.
- **Prescaler:**
  - Counts 0 … `TICK_DIV`−1 while `i_En` = 1 and `i_Set` = 0.
  - At terminal count it wraps to 0 and produces the internal second tick.
- **Natural advance** on a second tick:
  - Seconds units 0–9, carry into tens 0–5.
  - 59 → 00 carries into minutes with the same rule.
  - Minutes 59 → 00 carries into hours 00–23.
  - 23 → 00 raises `o_DayWrap`.
- **BCD digit rules:** every digit stays within 0–9. Tens digits stay within their ceiling: 5 for seconds and minutes, 2 for hours. Hours 19 → 20 is a units wrap with a tens increment. Hours 23 → 00 is a full wrap. Illegal BCD codes are never produced.
- **Set mode** (`i_Set` = 1):
  - Prescaler is held at 0. Seconds are forced to 00 on every cycle.
  - `o_SecPulse` and `o_DayWrap` stay 0.
  - `i_IncMin` increments minutes modulo 60 with no carry into hours.
  - `i_IncHr` increments hours modulo 24.
  - Simultaneous `i_IncMin` and `i_IncHr` apply both in the same cycle, independently.
- **Leaving set mode:** counting resumes from prescaler 0. The first tick therefore arrives `TICK_DIV` enabled cycles after `i_Set` falls.
- **`i_Set` precedence:** `i_Set` overrides `i_En`. Set mode works even when `i_En` is low.
- **Increment pulses outside set mode:** `i_IncMin` and `i_IncHr` are ignored when `i_Set` = 0.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- **Tick edge:** on the edge where the prescaler equals `TICK_DIV`−1 with `i_En` = 1 and `i_Set` = 0:
  - The new time value appears after that edge.
  - `o_SecPulse` is high for exactly that following cycle, aligned with the new `o_Sec`.
  - `o_DayWrap` is asserted in that same cycle, only when the new time is 00:00:00 via rollover.
- **Second period:** exactly `TICK_DIV` enabled cycles. Disabled cycles stretch the period without losing count.
- **Set-mode increment latency:** the updated value is visible on the cycle after the edge that samples the pulse. A pulse held high for k cycles increments k times, so debounced single-cycle pulses are the upstream's responsibility.
- **`i_Set` rising:** on the same edge a pending terminal count is discarded and seconds become 00.

## Structure
- **Shared package `clock_pkg`:**
  - BCD limit constants: `SEC_MAX` = 8'h59, `MIN_MAX` = 8'h59, `HR_MAX` = 8'h23.
  - Default `TICK_DIV`.
  - A `bcd2_t` 8-bit typedef, reused by display-side blocks.
- **Sub-module `bcd_mod_counter`:**
  - Parameterised two-digit BCD counter with a MAX value.
  - Inputs: `inc` and `clr`. Outputs: value and registered-next carry (`wrap` when value is MAX and `inc` = 1).
  - Instantiated three times. Hours use MAX = 8'h23.
- The prescaler lives in the top-level module.

## Test plan
- `TICK_DIV` = 4, reset, `i_En` = 1 → first `o_SecPulse` appears 4 cycles after reset release with `o_Sec` = 8'h01. Pulses are exactly 4 cycles apart and each is 1 cycle wide.
- Run to 00:00:59 → next tick gives `o_Sec` = 00, `o_Min` = 01. Run 23:59:59 → 00:00:00 with `o_DayWrap` high for 1 cycle, coincident with `o_SecPulse`.
- Hours traverse 09 → 10 and 19 → 20 → correct BCD (8'h10, 8'h20) with no 8'h0A or 8'h1A codes. Monitor every digit ≤ 9 throughout.
- `i_Set` = 1 at prescaler = 2 with `o_Sec` = 8'h37 → next cycle `o_Sec` = 00, no `o_SecPulse`. Minutes at 59 plus `i_IncMin` → `o_Min` = 00, `o_Hr` unchanged. `i_IncMin` and `i_IncHr` together at 23:59 → 00:00.
- `i_En` low for 10 cycles mid-second → period extends by exactly 10 cycles. `i_IncHr` with `i_Set` = 0 → no change.
- Assert `i_pRst` asynchronously between clock edges at 12:34:56 → all outputs 0 immediately. After release, count restarts with the full 4-cycle first period.
